gb_if_seq: RTL
==============

Name: gb_if_seq

Overview:
- Chip-side sequencer for the off-chip global-buffer port; sits between the internal clients (CCU config fetch, weight/activation loaders, output/pool writers) and the 3-channel pad interface: cfg, wr and rd.
- Arbitrates the client requests and issues a one-beat cfg command carrying a 4-bit info code.
- Then moves a fixed-length burst on the write channel (chip to host) or the read channel (host to chip), and returns a done pulse to the granted client.

Parameters:
- PORT_W, 128, width of the data port in bits.
- LEN_CFG, 64, beats for cmd 0 (layer config read).
- LEN_OUT, 64, beats for cmds 1 and 2 (output and pool writes).
- LEN_WADDR, 54, beats for cmd 3 (weight-address read).
- LEN_BLK, 512, beats for cmds 4..7 (weight data, weight flag, act data, act flag reads).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  8  per-command request from clients; bit k requests cmd k.
- gnt  out  8  one-hot; the cmd currently owning the port; held from cfg handshake until done.
- done  out  8  one-hot, 1-cycle pulse after the last beat of cmd k.
- GBIF_cfg_val  out  1  cfg command valid.
- IFGB_cfg_rdy  in  1  host accepts cfg.
- GBIF_cfg_info  out  4  [3:1] = cmd, [0] = 1 read (host to chip) / 0 write.
- GBIF_wr_val  out  1  write beat valid.
- IFGB_wr_rdy  in  1  host accepts write beat.
- GBIF_wr_data  out  PORT_W  write beat data.
- IFGB_rd_val  in  1  host read beat valid.
- GBIF_rd_rdy  out  1  chip accepts read beat.
- IFGB_rd_data  in  PORT_W  read beat data.
- src_val  in  1  client write data valid.
- src_data  in  PORT_W  client write data.
- src_rdy  out  1  client write data consumed.
- snk_val  out  1  read data to client valid.
- snk_data  out  PORT_W  read data to client.
- snk_rdy  in  1  client can take read data.

Behaviour:
- Reset:
  - all outputs 0; state IDLE; beat counter 0; latched cmd 0.
  - Async assertion mid-burst aborts immediately; no done pulse is issued; the partial burst is discarded.
- States: IDLE, CFG, XFER, DONE.
- IDLE:
  - If req != 0, latch cmd = index of lowest set bit (fixed priority, cmd 0 highest) and go to CFG next cycle.
  - req is sampled only in IDLE; changes in other states are ignored.
- CFG:
  - GBIF_cfg_val = 1; GBIF_cfg_info = {cmd, dir}, where dir = 0 for cmd 1,2 and 1 otherwise.
  - Info is registered and stable while val is high.
  - On cfg_val & cfg_rdy: gnt[cmd] = 1, counter = 0, go to XFER.
  - cfg_val then drops the next cycle; no second cfg is ever issued back-to-back.
- XFER, write (dir = 0):
  - GBIF_wr_val = src_val; GBIF_wr_data = src_data; src_rdy = IFGB_wr_rdy. Both paths are combinational pass-through.
  - A beat is counted on wr_val & wr_rdy.
  - GBIF_rd_rdy and snk_val are 0.
- XFER, read (dir = 1):
  - snk_val = IFGB_rd_val; snk_data = IFGB_rd_data; GBIF_rd_rdy = snk_rdy.
  - A beat is counted on rd_val & rd_rdy.
  - wr_val and src_rdy are 0.
- Beat counter:
  - 10 bits, increments per counted beat.
  - When a beat is counted with counter == LEN(cmd) - 1, go to DONE; the counter is not incremented past the last beat.
  - Any stall on either side of the handshake simply holds the counter.
- DONE (1 cycle):
  - done[cmd] = 1; gnt cleared at the end of the cycle; all channel outputs 0; return to IDLE.
  - A request pending in DONE is served from IDLE on the following cycle, so the minimum gap between bursts is 2 cycles (DONE, IDLE).
- GBIF_cfg_info holds its last value outside CFG; host-side logic may rely on it through the whole burst.
- Handshake rule: val must not depend on rdy on any channel output. wr_val follows src_val only, and cfg_val is state-driven.

Test Plan:
- req = 8'h01, cfg_rdy after 3 cycles, rd_val/snk_rdy always 1 -> cfg_info = 4'b0001; 64 snk_val beats; done[0] pulses exactly 1 cycle after beat 64; gnt = 8'h01 throughout the burst.
- req = 8'h02, src_val always 1, wr_rdy random 50% -> cfg_info = 4'b0010; exactly 64 counted wr beats carrying src_data in order; done[1] pulse; rd_rdy stays 0.
- req = 8'h18 simultaneous -> cmd 3 served first (54 beats, cfg_info = 4'b0111), then cmd 4 (512 beats, cfg_info = 4'b1001) after the 2-cycle gap.
- cmd 6 read with snk_rdy toggling 1-0-1 and rd_val random -> counter advances only on rd_val & rd_rdy; 512 beats; snk_data equals the host sequence with no drops or duplicates.
- rst_n asserted at beat 200 of cmd 7 -> all outputs 0 in the same cycle; no done; after release with req[7] still high, a fresh cfg with counter restarting from 0.
- req toggled during XFER of cmd 5 -> gnt and the latched cmd are unchanged; the new request is served only after done[5].

Source files
------------

// File: rtl/gb_if_seq.sv
// Global-buffer port sequencer: arbitrates client commands, issues one cfg beat,
// then streams a fixed-length burst on the write or read channel and pulses done.
module gb_if_seq #(
  parameter int PORT_W    = 128,
  parameter int LEN_CFG   = 64,
  parameter int LEN_OUT   = 64,
  parameter int LEN_WADDR = 54,
  parameter int LEN_BLK   = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        req,
  output logic [7:0]        gnt,
  output logic [7:0]        done,
  output logic              GBIF_cfg_val,
  input  logic              IFGB_cfg_rdy,
  output logic [3:0]        GBIF_cfg_info,
  output logic              GBIF_wr_val,
  input  logic              IFGB_wr_rdy,
  output logic [PORT_W-1:0] GBIF_wr_data,
  input  logic              IFGB_rd_val,
  output logic              GBIF_rd_rdy,
  input  logic [PORT_W-1:0] IFGB_rd_data,
  input  logic              src_val,
  input  logic [PORT_W-1:0] src_data,
  output logic              src_rdy,
  output logic              snk_val,
  output logic [PORT_W-1:0] snk_data,
  input  logic              snk_rdy
);

  typedef enum logic [1:0] {IDLE, CFG, XFER, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cmd;
  logic        dir;
  logic [9:0]  cnt;
  logic [9:0]  last_idx;
  logic [3:0]  info_r;
  logic [2:0]  req_idx;
  logic        req_dir;
  logic        beat;

  // Fixed priority: lowest set bit wins, cmd 0 highest.
  function automatic logic [2:0] lowest_set(input logic [7:0] r);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [9:0] beat_len(input logic [2:0] c);
    logic [9:0] n;
    case (c)
      3'd0:       n = 10'(LEN_CFG);
      3'd1, 3'd2: n = 10'(LEN_OUT);
      3'd3:       n = 10'(LEN_WADDR);
      default:    n = 10'(LEN_BLK);
    endcase
    return n;
  endfunction

  // Only the output/pool writers move data chip-to-host.
  function automatic logic dir_of(input logic [2:0] c);
    return !((c == 3'd1) || (c == 3'd2));
  endfunction

  assign req_idx = lowest_set(req);
  assign req_dir = dir_of(req_idx);

  // Beat qualification uses the raw inputs so no val output depends on a rdy.
  assign beat = (state == XFER) &&
                (dir ? (IFGB_rd_val & snk_rdy) : (src_val & IFGB_wr_rdy));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req != 8'd0) state_nxt = CFG;
      CFG:  if (IFGB_cfg_rdy) state_nxt = XFER;
      XFER: if (beat && (cnt == last_idx)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd      <= 3'd0;
      dir      <= 1'b0;
      cnt      <= 10'd0;
      last_idx <= 10'd0;
      info_r   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 8'd0) begin
            cmd      <= req_idx;
            dir      <= req_dir;
            info_r   <= {req_idx, req_dir};
            last_idx <= beat_len(req_idx) - 10'd1;
          end
        end
        CFG: begin
          if (IFGB_cfg_rdy) cnt <= 10'd0;
        end
        XFER: begin
          if (beat && (cnt != last_idx)) cnt <= cnt + 10'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt           = 8'd0;
    done          = 8'd0;
    GBIF_cfg_val  = 1'b0;
    GBIF_cfg_info = info_r;
    GBIF_wr_val   = 1'b0;
    GBIF_wr_data  = '0;
    src_rdy       = 1'b0;
    snk_val       = 1'b0;
    snk_data      = '0;
    GBIF_rd_rdy   = 1'b0;
    case (state)
      CFG: GBIF_cfg_val = 1'b1;
      XFER: begin
        gnt = 8'b1 << cmd;
        if (dir) begin
          snk_val     = IFGB_rd_val;
          snk_data    = IFGB_rd_data;
          GBIF_rd_rdy = snk_rdy;
        end else begin
          GBIF_wr_val  = src_val;
          GBIF_wr_data = src_data;
          src_rdy      = IFGB_wr_rdy;
        end
      end
      DONE: begin
        gnt  = 8'b1 << cmd;
        done = 8'b1 << cmd;
      end
      default: ;
    endcase
  end

endmodule
